// File: rtl/perm_cfg_sched.sv
// perm_cfg_sched
//   Arbitrates configuration requests for a permutation network. A granted
//   word is checked to be a bijection (every slice destination used exactly
//   once), passed through the external address decoder, and the decoded
//   select word is then presented to the datapath for len+1 beats.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_dat, req_len      per-requester config word and beat count minus one
//   dec_t_dat             config word toward the address decoder
//   dec_i_dat             combinational select word back from the decoder
//   run_valid/run_ready   select-word handshake toward the datapath
//   run_sel, run_last     registered select word, final beat of the grant
//   run_id                index of the granted requester
//   err_dup               one-cycle pulse when a request is not a bijection
//   busy                  FSM is not idle
module perm_cfg_sched #(
   parameter int unsigned SLICES     = 8,
   parameter int unsigned LOG2SLICES = 3,
   parameter int unsigned SELOU      = 8,
   parameter int unsigned NREQ       = 4,
   parameter int unsigned W          = SELOU + SLICES * LOG2SLICES
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*W-1:0]        req_dat,
   input  logic [NREQ*8-1:0]        req_len,
   output logic [W-1:0]             dec_t_dat,
   input  logic [W-1:0]             dec_i_dat,
   output logic                     run_valid,
   input  logic                     run_ready,
   output logic [W-1:0]             run_sel,
   output logic                     run_last,
   output logic [$clog2(NREQ)-1:0]  run_id,
   output logic                     err_dup,
   output logic                     busy
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam logic [LOG2SLICES-1:0] C_LAST = LOG2SLICES'(SLICES - 1);

   typedef enum logic [1:0] {IDLE, CHECK, LOAD, RUN} state_t;

   state_t                  state, state_nxt;
   logic [W-1:0]            cfg_reg;
   logic [W-1:0]            sel_reg;
   logic [7:0]              len_reg;
   logic [7:0]              b;
   logic [LOG2SLICES-1:0]   c;
   logic [SLICES-1:0]       seen;
   logic [IDW-1:0]          rr_ptr;

   logic [NREQ-1:0]         gnt;
   logic [IDW-1:0]          gnt_idx;
   logic                    accept;
   logic [W-1:0]            acc_dat;
   logic [7:0]              acc_len;
   logic [LOG2SLICES-1:0]   dest;
   logic                    dup;

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      for (int unsigned o = 1; o <= NREQ; o++) begin
         int unsigned idx;
         idx = (32'(rr_ptr) + o) % NREQ;
         if (gnt == '0 && req_valid[idx[IDW-1:0]]) begin
            gnt[idx[IDW-1:0]] = 1'b1;
            gnt_idx           = idx[IDW-1:0];
         end
      end
   end

   // Gating with reset_n keeps req_ready low while reset is held even though
   // the state already reads IDLE.
   assign req_ready = (state == IDLE && reset_n) ? gnt : '0;
   assign accept    = |req_ready;

   always_comb begin
      acc_dat = '0;
      acc_len = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (gnt[k]) begin
            acc_dat = req_dat[k*W +: W];
            acc_len = req_len[k*8 +: 8];
         end
      end
   end

   // Destination of the slot currently under check.
   always_comb begin
      dest = '0;
      for (int unsigned i = 0; i < SLICES; i++) begin
         if (c == LOG2SLICES'(i)) dest = cfg_reg[i*LOG2SLICES +: LOG2SLICES];
      end
   end

   assign dup = seen[dest];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      err_dup   = 1'b0;
      run_valid = 1'b0;
      run_last  = 1'b0;
      busy      = (state != IDLE);
      run_sel   = sel_reg;
      dec_t_dat = cfg_reg;
      case (state)
         IDLE:  if (accept) state_nxt = CHECK;
         CHECK: begin
            if (dup) begin
               err_dup   = 1'b1;
               state_nxt = IDLE;
            end else if (c == C_LAST) begin
               state_nxt = LOAD;
            end
         end
         LOAD:  state_nxt = RUN;
         RUN: begin
            run_valid = 1'b1;
            run_last  = (b == len_reg);
            if (run_ready && b == len_reg) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfg_reg <= '0;
         sel_reg <= '0;
         len_reg <= '0;
         b       <= '0;
         c       <= '0;
         seen    <= '0;
         run_id  <= '0;
         rr_ptr  <= IDW'(NREQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cfg_reg <= acc_dat;
                  len_reg <= acc_len;
                  run_id  <= gnt_idx;
                  rr_ptr  <= gnt_idx;
                  c       <= '0;
                  seen    <= '0;
               end
            end
            CHECK: begin
               if (!dup) begin
                  seen[dest] <= 1'b1;
                  c          <= c + 1'b1;
               end
            end
            LOAD: begin
               sel_reg <= dec_i_dat;
               b       <= '0;
            end
            RUN: begin
               if (run_ready) begin
                  if (b == len_reg) b <= '0;
                  else              b <= b + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_perm_cfg_sched.sv
// tb_perm_cfg_sched
//   Directed bench for perm_cfg_sched. Stimulus pushes expected beats and
//   duplicate-error events into a scoreboard queue; a negedge monitor pops
//   and compares whenever the DUT completes a beat or pulses err_dup.
//   The address decoder is modelled as the inverse permutation with the
//   SELOU field passed straight through.
module tb_perm_cfg_sched;

   localparam int unsigned SLICES = 8;
   localparam int unsigned L      = 3;
   localparam int unsigned SELOU  = 8;
   localparam int unsigned NREQ   = 4;
   localparam int unsigned DW     = SLICES * L;
   localparam int unsigned W      = SELOU + DW;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*W-1:0]   req_dat;
   logic [NREQ*8-1:0]   req_len;
   logic [W-1:0]        dec_t_dat;
   logic [W-1:0]        dec_i_dat;
   logic                run_valid;
   logic                run_ready;
   logic [W-1:0]        run_sel;
   logic                run_last;
   logic [1:0]          run_id;
   logic                err_dup;
   logic                busy;

   perm_cfg_sched #(.SLICES(SLICES), .LOG2SLICES(L), .SELOU(SELOU), .NREQ(NREQ)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_dat(req_dat), .req_len(req_len),
      .dec_t_dat(dec_t_dat), .dec_i_dat(dec_i_dat),
      .run_valid(run_valid), .run_ready(run_ready), .run_sel(run_sel),
      .run_last(run_last), .run_id(run_id), .err_dup(err_dup), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] decode(input logic [W-1:0] t);
      logic [W-1:0] o;
      logic [L-1:0] d;
      o = '0;
      o[W-1:DW] = t[W-1:DW];
      for (int i = 0; i < SLICES; i++) begin
         d = t[i*L +: L];
         o[32'(d)*L +: L] = L'(i);
      end
      return o;
   endfunction

   assign dec_i_dat = decode(dec_t_dat);

   typedef struct {
      bit           is_err;
      logic [W-1:0] sel;
      bit           last;
      logic [1:0]   id;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int unsigned   total = 0;
   int unsigned   bad   = 0;
   logic [W-1:0]  w_sel [NREQ];
   logic [7:0]    w_len [NREQ];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_beats(input int unsigned k, input logic [W-1:0] sel, input int unsigned n);
      exp_t e;
      for (int unsigned i = 0; i < n; i++) begin
         e.is_err = 1'b0;
         e.sel    = sel;
         e.last   = (i == n - 1);
         e.id     = 2'(k);
         sb.push_back(e);
      end
   endtask

   task automatic push_err;
      exp_t e;
      e.is_err = 1'b1;
      e.sel    = '0;
      e.last   = 1'b0;
      e.id     = '0;
      sb.push_back(e);
   endtask

   task automatic set_req(input int unsigned k, input logic [W-1:0] dat,
                          input logic [7:0] len, input logic [W-1:0] esel);
      req_dat[k*W +: W] = dat;
      req_len[k*8 +: 8] = len;
      w_sel[k] = esel;
      w_len[k] = len;
   endtask

   // Expects n grants in the order packed two bits per grant in 'order'.
   task automatic grant_seq(input int unsigned n, input logic [7:0] order);
      int unsigned     got = 0;
      int unsigned     cyc = 0;
      logic [1:0]      k;
      logic [NREQ-1:0] oh;
      while (got < n && cyc < 400) begin
         if (req_ready != '0) begin
            k = order[2*got +: 2];
            oh = '0;
            oh[k] = 1'b1;
            chk("grant_order", W'(req_ready), W'(oh));
            push_beats(k, w_sel[k], 32'(w_len[k]) + 1);
            got++;
         end
         tick;
         cyc++;
      end
      chk("grant_count", W'(got), W'(n));
      req_valid = '0;
   endtask

   task automatic wait_drain;
      int unsigned cyc = 0;
      while ((busy || sb.size() != 0) && cyc < 2000) begin
         tick;
         cyc++;
      end
      chk("drain_busy", W'(busy), '0);
      chk("drain_sb", W'(sb.size()), '0);
   endtask

   task automatic wait_run;
      int unsigned cyc = 0;
      while (!run_valid && cyc < 50) begin
         tick;
         cyc++;
      end
      chk("run_start", W'(run_valid), W'(1));
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (err_dup || (run_valid && run_ready))
            chk("err_hs_overlap", W'(err_dup && run_valid && run_ready), '0);
         if (run_valid && run_ready) begin
            if (sb.size() == 0) chk("sb_has_beat", W'(sb.size()), W'(1));
            else begin
               mon_e = sb.pop_front();
               chk("beat_kind", W'(mon_e.is_err), '0);
               chk("beat_sel", run_sel, mon_e.sel);
               chk("beat_last", W'(run_last), W'(mon_e.last));
               chk("beat_id", W'(run_id), W'(mon_e.id));
            end
         end
         if (err_dup) begin
            if (sb.size() == 0) chk("sb_has_err", W'(sb.size()), W'(1));
            else begin
               mon_e = sb.pop_front();
               chk("err_kind", W'(mon_e.is_err), W'(1));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] word;
      logic [7:0]   selou;
      int unsigned  p [SLICES];
      int unsigned  j, tmp;

      reset_n   = 1'b0;
      run_ready = 1'b1;
      req_dat   = '0;
      req_len   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sel[k] = '0;
         w_len[k] = '0;
      end
      req_valid = '1;
      #1;
      tick;
      tick;
      chk("rst_req_ready", W'(req_ready), '0);
      chk("rst_run_valid", W'(run_valid), '0);
      chk("rst_run_last", W'(run_last), '0);
      chk("rst_err_dup", W'(err_dup), '0);
      chk("rst_busy", W'(busy), '0);
      chk("rst_run_sel", run_sel, '0);
      chk("rst_run_id", W'(run_id), '0);
      chk("rst_dec_t", dec_t_dat, '0);
      req_valid = '0;
      tick;
      reset_n = 1'b1;
      tick;

      // Round-robin between requesters 0 and 3, two beats each.
      set_req(0, {8'h11, 24'hFAC688}, 8'd1, {8'h11, 24'hFAC688});
      set_req(3, {8'h33, 24'h053977}, 8'd1, {8'h33, 24'h053977});
      req_valid = 4'b1001;
      #1;
      grant_seq(4, 8'hCC);
      wait_drain;

      // Single request from requester 2, identity, len 0: exact latency.
      tick;
      set_req(2, {8'hA5, 24'hFAC688}, 8'd0, {8'hA5, 24'hFAC688});
      req_valid = 4'b0100;
      #1;
      chk("s_ready", W'(req_ready), W'(4'b0100));
      push_beats(2, w_sel[2], 1);
      for (int unsigned n = 1; n <= 11; n++) begin
         tick;
         if (n == 1) req_valid = '0;
         if (n == 9) chk("s_valid_c9", W'(run_valid), '0);
         if (n == 10) begin
            chk("s_valid_c10", W'(run_valid), W'(1));
            chk("s_last_c10", W'(run_last), W'(1));
            chk("s_id_c10", W'(run_id), W'(2));
         end
         if (n == 11) chk("s_busy_c11", W'(busy), '0);
      end
      wait_drain;

      // Duplicate destinations from requester 1.
      set_req(1, {8'h3C, 24'h000000}, 8'd0, '0);
      req_valid = 4'b0010;
      #1;
      chk("d_ready", W'(req_ready), W'(4'b0010));
      push_err;
      tick;
      req_valid = '0;
      #1;
      chk("d_err_c0", W'(err_dup), '0);
      chk("d_busy_c0", W'(busy), W'(1));
      tick;
      chk("d_err_c1", W'(err_dup), W'(1));
      tick;
      chk("d_err_after", W'(err_dup), '0);
      chk("d_busy_after", W'(busy), '0);
      for (int unsigned n = 0; n < 4; n++) begin
         chk("d_no_run", W'(run_valid), '0);
         tick;
      end
      wait_drain;

      // Backpressure: requester 0, len 3, five stall cycles after beat 2.
      set_req(0, {8'h5A, 24'h053977}, 8'd3, {8'h5A, 24'h053977});
      req_valid = 4'b0001;
      #1;
      chk("bp_ready", W'(req_ready), W'(4'b0001));
      push_beats(0, w_sel[0], 4);
      tick;
      req_valid = '0;
      wait_run;
      tick;
      tick;
      run_ready = 1'b0;
      #1;
      for (int unsigned s = 0; s < 5; s++) begin
         chk("bp_valid", W'(run_valid), W'(1));
         chk("bp_last", W'(run_last), '0);
         chk("bp_sel", run_sel, {8'h5A, 24'h053977});
         chk("bp_id", W'(run_id), '0);
         tick;
      end
      run_ready = 1'b1;
      wait_drain;

      // Decoder loopback with random permutations from requester 1.
      for (int unsigned rep = 0; rep < 3; rep++) begin
         for (int unsigned i = 0; i < SLICES; i++) p[i] = i;
         for (int unsigned i = SLICES - 1; i >= 1; i--) begin
            j = $urandom_range(i, 0);
            tmp = p[i];
            p[i] = p[j];
            p[j] = tmp;
         end
         selou = 8'($urandom);
         word = '0;
         word[W-1:DW] = selou;
         for (int unsigned i = 0; i < SLICES; i++) word[i*L +: L] = L'(p[i]);
         set_req(1, word, 8'd0, decode(word));
         req_valid = 4'b0010;
         #1;
         chk("lb_ready", W'(req_ready), W'(4'b0010));
         push_beats(1, w_sel[1], 1);
         tick;
         req_valid = '0;
         #1;
         chk("lb_dec_t", dec_t_dat, word);
         wait_run;
         chk("lb_selou", W'(run_sel[W-1:DW]), W'(selou));
         wait_drain;
      end

      // Reset during RUN at b=1, then priority restarts from requester 0.
      set_req(2, {8'h77, 24'hFAC688}, 8'd3, {8'h77, 24'hFAC688});
      req_valid = 4'b0100;
      #1;
      chk("rr_ready", W'(req_ready), W'(4'b0100));
      push_beats(2, w_sel[2], 1);
      sb[sb.size() - 1].last = 1'b0;
      tick;
      req_valid = '0;
      wait_run;
      tick;
      reset_n = 1'b0;
      #1;
      chk("rr_valid_rst", W'(run_valid), '0);
      chk("rr_last_rst", W'(run_last), '0);
      chk("rr_busy_rst", W'(busy), '0);
      chk("rr_sel_rst", run_sel, '0);
      chk("rr_sb_empty", W'(sb.size()), '0);
      set_req(0, {8'h01, 24'hFAC688}, 8'd0, {8'h01, 24'hFAC688});
      set_req(1, {8'h02, 24'h053977}, 8'd0, {8'h02, 24'h053977});
      req_valid = 4'b0011;
      #1;
      chk("rr_ready_rst", W'(req_ready), '0);
      tick;
      reset_n = 1'b1;
      #1;
      grant_seq(2, 8'h04);
      wait_drain;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
